// File: rtl/ram_256_burst_ctrl.sv
// ram_256_burst_ctrl - burst master for a RAM_256 style single-port RAM.
// Accepts write/read burst commands on a valid/ready port, streams write beats
// into the RAM and read beats out of it, hiding the RAM pin timing.
// Optional feature: define RAM_256_BURST_CHKSUM_EN to add chksum_o, the XOR of
// every beat moved by the current (or most recent) burst.
module ram_256_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [7:0]        cmd_len_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_cs_o,
    output logic              ram_w_r_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i
`ifdef RAM_256_BURST_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] chksum_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BEAT,
        S_RD_ADDR,
        S_RD_CAP,
        S_RD_HOLD,
        S_FIN
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                done_q;

    logic cmd_fire;
    logic wr_fire;
    logic rd_fire;
    logic last_beat;

    assign cmd_fire  = (state_q == S_IDLE) && cmd_valid_i;
    assign wr_fire   = (state_q == S_WR_BEAT) && wr_valid_i;
    assign rd_fire   = (state_q == S_RD_HOLD) && rd_ready_i;
    assign last_beat = (cnt_q == len_q);

    // Burst sequencer: state, address/beat counters and registered read/done outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        addr_q  <= cmd_addr_i;
                        len_q   <= cmd_len_i;
                        cnt_q   <= '0;
                        state_q <= cmd_wr_i ? S_WR_BEAT : S_RD_ADDR;
                    end
                end
                S_WR_BEAT: begin
                    // The RAM captures the beat on this same edge; just advance.
                    if (wr_fire) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q + 8'd1;
                        if (last_beat) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RD_ADDR: begin
                    state_q <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    rd_data_q  <= ram_dout_i;
                    rd_valid_q <= 1'b1;
                    state_q    <= S_RD_HOLD;
                end
                S_RD_HOLD: begin
                    // Beat stays on rd_data_o until the consumer takes it.
                    if (rd_fire) begin
                        rd_valid_q <= 1'b0;
                        if (last_beat) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            cnt_q   <= cnt_q + 8'd1;
                            state_q <= S_RD_ADDR;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM pin drive: decoded from the state so an async reset drops CS at once.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ram_cs_o  = 1'b0;
        ram_w_r_o = 1'b0;
        ram_din_o = '0;
        case (state_q)
            S_WR_BEAT: begin
                ram_cs_o  = wr_valid_i;
                ram_w_r_o = wr_valid_i;
                ram_din_o = wr_data_i;
            end
            S_RD_ADDR, S_RD_CAP: begin
                ram_cs_o = 1'b1;
            end
            default: begin
                ram_cs_o = 1'b0;
            end
        endcase
    end

    assign ram_addr_o  = addr_q;
    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign wr_ready_o  = (state_q == S_WR_BEAT);
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign done_o      = done_q;

`ifdef RAM_256_BURST_CHKSUM_EN
    logic [DATA_W-1:0] chksum_q;

    // Running XOR of the beats of the current burst; cleared when a new one starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum_q <= '0;
        end else if (cmd_fire) begin
            chksum_q <= '0;
        end else if (wr_fire) begin
            chksum_q <= chksum_q ^ wr_data_i;
        end else if (rd_fire) begin
            chksum_q <= chksum_q ^ rd_data_q;
        end
    end

    assign chksum_o = chksum_q;
`endif

endmodule

// File: tb/tb_ram_256_burst_ctrl.sv
// Testbench for ram_256_burst_ctrl: a RAM_256 behavioural model on the pins,
// a shadow memory as reference, and a negedge monitor that pops expected RAM
// writes and read beats from queues filled when each burst is issued.
module tb_ram_256_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [7:0] cmd_addr, cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, rd_ready;
    logic       busy, done;
    logic       ram_cs, ram_w_r;
    logic [7:0] ram_addr, ram_din, ram_dout;
`ifdef RAM_256_BURST_CHKSUM_EN
    logic [7:0] chksum;
`endif

    logic [7:0]  mem       [256];
    logic [7:0]  ref_mem   [256];
    logic [7:0]  beat_data [256];
    logic [15:0] wr_exp_q  [$];
    logic [7:0]  rd_exp_q  [$];

    int checks = 0;
    int errors = 0;

    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clk = ~clk;

    ram_256_burst_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_wr_i    (cmd_wr),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .wr_data_i   (wr_data),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .rd_ready_i  (rd_ready),
        .busy_o      (busy),
        .done_o      (done),
        .ram_cs_o    (ram_cs),
        .ram_w_r_o   (ram_w_r),
        .ram_addr_o  (ram_addr),
        .ram_din_o   (ram_din),
        .ram_dout_i  (ram_dout)
`ifdef RAM_256_BURST_CHKSUM_EN
        ,
        .chksum_o    (chksum)
`endif
    );

    // RAM_256 model: synchronous write, asynchronous read, junk when not selected.
    always @(posedge clk) begin
        if (ram_cs && ram_w_r) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = (ram_cs && !ram_w_r) ? mem[ram_addr] : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected RAM writes / read beats and checks read-hold rules.
    always @(negedge clk) begin
        logic [15:0] w;
        logic [7:0]  r;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("rd_hold_valid", 32'(rd_valid), 32'd1);
                check("rd_hold_data", 32'(rd_data), 32'(prev_data));
            end
            if (rd_valid) begin
                check("rd_hold_cs", 32'(ram_cs), 32'd0);
                check("rd_hold_wr", 32'(ram_w_r), 32'd0);
            end
            if (ram_cs && ram_w_r) begin
                if (wr_exp_q.size() == 0) begin
                    check("wr_queue_depth", 32'(wr_exp_q.size()), 32'd1);
                end else begin
                    w = wr_exp_q.pop_front();
                    check("ram_wr_addr", 32'(ram_addr), 32'(w[15:8]));
                    check("ram_wr_data", 32'(ram_din), 32'(w[7:0]));
                end
            end
            if (rd_valid && rd_ready) begin
                if (rd_exp_q.size() == 0) begin
                    check("rd_queue_depth", 32'(rd_exp_q.size()), 32'd1);
                end else begin
                    r = rd_exp_q.pop_front();
                    check("rd_beat_data", 32'(rd_data), 32'(r));
                end
            end
            stall_prev = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    // Issue one burst and drive its beats; called #1 after a posedge.
    task automatic run_burst(input bit wr, input logic [7:0] addr, input logic [7:0] len,
                             input int stall_pct, input int hold);
        int         beats;
        int         sent;
        int         cyc;
        bit         seen;
        logic [7:0] a;
        logic [7:0] sum;
        beats = int'(len) + 1;
        sent  = 0;
        seen  = 1'b0;
        sum   = 8'h00;
        for (int i = 0; i < beats; i++) begin
            a = addr + 8'(i);
            if (wr) begin
                wr_exp_q.push_back({a, beat_data[i]});
                ref_mem[a] = beat_data[i];
                sum ^= beat_data[i];
            end else begin
                rd_exp_q.push_back(ref_mem[a]);
                sum ^= ref_mem[a];
            end
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
        cyc = 0;
        while (!seen && cyc < 4000) begin
            cyc++;
            if (wr) begin
                wr_valid = (sent < beats) && ($urandom_range(99) >= stall_pct);
                wr_data  = wr_valid ? beat_data[sent] : 8'($urandom);
            end else begin
                rd_ready = (cyc > hold) && ($urandom_range(99) >= stall_pct);
            end
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_after_accept", 32'(busy), 32'd1);
                check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
`ifdef RAM_256_BURST_CHKSUM_EN
                check("chksum_cleared", 32'(chksum), 32'd0);
`endif
            end
            if (wr && wr_valid && wr_ready) sent++;
            if (done) begin
                seen = 1'b1;
                if (stall_pct == 0 && hold == 0)
                    check("done_latency", 32'(cyc), wr ? 32'(beats + 1) : 32'(3 * beats + 1));
`ifdef RAM_256_BURST_CHKSUM_EN
                check("chksum_at_done", 32'(chksum), 32'(sum));
`endif
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
`ifdef RAM_256_BURST_CHKSUM_EN
        check("chksum_holds", 32'(chksum), 32'(sum));
`endif
        check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        wr_exp_q.delete();
        rd_exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 8'h00;
        wr_data   = 8'h00;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Reset values
        #3;
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_w_r", 32'(ram_w_r), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the whole RAM with one 256-beat write that wraps past 0xFF
        for (int i = 0; i < 256; i++) beat_data[i] = 8'($urandom);
        run_burst(1'b1, 8'h80, 8'hFF, 20, 0);

        // Two-beat write, no stalls
        beat_data[0] = 8'h3F;
        beat_data[1] = 8'h03;
        run_burst(1'b1, 8'h0D, 8'h01, 0, 0);

        // Read it back with the consumer holding off for several cycles
        run_burst(1'b0, 8'h0D, 8'h01, 0, 8);

        // Wrapping write then read back without stalls
        beat_data[0] = 8'hA1;
        beat_data[1] = 8'hA2;
        beat_data[2] = 8'hA3;
        run_burst(1'b1, 8'hFE, 8'h02, 0, 0);
        run_burst(1'b0, 8'hFE, 8'h02, 0, 0);
        check("wrap_mem_ff", 32'(mem[8'hFF]), 32'h0A2);
        check("wrap_mem_00", 32'(mem[8'h00]), 32'h0A3);

        // Single-beat bursts
        beat_data[0] = 8'h5C;
        run_burst(1'b1, 8'h40, 8'h00, 0, 0);
        run_burst(1'b0, 8'h40, 8'h00, 0, 0);

        // Command while busy is ignored; reset mid-read aborts without DONE
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 8'h10;
        cmd_len   = 8'd3;
        @(negedge clk);
        check("t5_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_wr   = 1'b1;
        cmd_addr = 8'h77;
        @(negedge clk);
        check("t5_ready_busy", 32'(cmd_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_rd_addr_cs", 32'(ram_cs), 32'd1);
        check("t5_rd_addr_wr", 32'(ram_w_r), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t5_addr_kept", 32'(ram_addr), 32'h10);
        check("t5_rd_cap_cs", 32'(ram_cs), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_abort_cs", 32'(ram_cs), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t5_no_done", 32'(done), 32'd0);
            check("t5_no_rd_valid", 32'(rd_valid), 32'd0);
            check("t5_stays_idle", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;

        // Full-length read over the whole RAM with random back-pressure
        run_burst(1'b0, 8'hC3, 8'hFF, 30, 0);

        // Randomized mix of short bursts
        for (int n = 0; n < 24; n++) begin
            logic       w;
            logic [7:0] a;
            logic [7:0] l;
            w = 1'($urandom_range(1));
            a = 8'($urandom);
            l = 8'($urandom_range(15));
            for (int i = 0; i <= int'(l); i++) beat_data[i] = 8'($urandom);
            run_burst(w, a, l, 30, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
